// File: rtl/filter_feedback_pkg.sv
// filter_feedback_pkg: shared sample format, FSM state encodings and saturation helper
// Contents: DATA_W, SAMPLE_MAX/SAMPLE_MIN limits, state_t, sat() clamping a 17-bit sum to 16 bits.
package filter_feedback_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] SAMPLE_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAMPLE_MIN = 16'h8000;
  typedef enum logic [2:0] {CLEAR, IDLE, READ, MUL, WRITE} state_t;
  // Overflow shows up as the two top bits disagreeing; the top bit gives the direction.
  function automatic logic [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
    return (v[DATA_W] == v[DATA_W-1]) ? v[DATA_W-1:0] : (v[DATA_W] ? SAMPLE_MIN : SAMPLE_MAX);
  endfunction
endpackage

// File: rtl/filter_feedback_if.sv
// filter_feedback_if: sample stream handshake between source, filter and output stage
// Signals: audio_in/in_valid/gain from the source, in_ready back to it; audio_out/out_valid from the filter.
interface filter_feedback_if #(parameter int GAIN_W = 8);
  import filter_feedback_pkg::*;
  logic [DATA_W-1:0] audio_in;
  logic              in_valid;
  logic              in_ready;
  logic [GAIN_W-1:0] gain;
  logic [DATA_W-1:0] audio_out;
  logic              out_valid;
  modport master (output audio_in, in_valid, gain, input in_ready, audio_out, out_valid);
  modport slave (input audio_in, in_valid, gain, output in_ready, audio_out, out_valid);
endinterface

// File: rtl/filter_delay_ram.sv
// filter_delay_ram: single-port synchronous delay-line RAM with one-cycle read latency
// Ports: clk, we (write enable), addr, wdata, rdata (registered read of addr, no array reset).
module filter_delay_ram import filter_feedback_pkg::*; #(
  parameter int DELAY_LEN = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DELAY_LEN];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/filter_feedback.sv
// filter_feedback: feedback comb filter y[n] = x[n] + g/256 * y[n-DELAY_LEN], saturated
// Ports: clk, rst_n (async active-low), bus (slave side of filter_feedback_if sample stream).
module filter_feedback import filter_feedback_pkg::*; #(
  parameter int DELAY_LEN = 1024,
  parameter int ADDR_W = $clog2(DELAY_LEN),
  parameter int GAIN_W = 8
) (
  input logic clk,
  input logic rst_n,
  filter_feedback_if.slave bus
);
  localparam int P_W = DATA_W + GAIN_W + 1;
  state_t state, next;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] x;
  logic [GAIN_W-1:0] g;
  logic signed [P_W-1:0] p;
  logic signed [DATA_W:0] s;
  logic we, last;
  logic [DATA_W-1:0] wdata, rdata;
  filter_delay_ram #(.DELAY_LEN(DELAY_LEN), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(we), .addr(ptr), .wdata(wdata), .rdata(rdata)
  );
  assign last = ptr == ADDR_W'(DELAY_LEN - 1);
  // Floor-shifted product plus sign-extended input; fits 17 bits for any gain below 1.0.
  assign s = {x[DATA_W-1], x} + (DATA_W + 1)'(p >>> GAIN_W);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else state <= next;
  end
  always_comb begin
    next = state;
    next = (state == CLEAR) ? (last ? IDLE : CLEAR) :
           (state == IDLE)  ? (bus.in_valid ? READ : IDLE) :
           (state == READ)  ? MUL :
           (state == MUL)   ? WRITE : IDLE;
  end
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == WRITE;
    we = (state == CLEAR) || (state == WRITE);
    wdata = (state == WRITE) ? bus.audio_out : '0;
  end
  // The RAM address is always ptr, so IDLE continuously reads y[n-D] for the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      x <= '0;
      g <= '0;
      p <= '0;
      bus.audio_out <= '0;
    end else begin
      if (we) ptr <= ptr + 1'b1;
      if (state == IDLE && bus.in_valid) begin
        x <= bus.audio_in;
        g <= bus.gain;
      end
      if (state == READ) p <= P_W'($signed(rdata)) * P_W'($signed({1'b0, g}));
      if (state == MUL) bus.audio_out <= sat(s);
    end
  end
endmodule

// File: tb/tb_filter_feedback.sv
// tb_filter_feedback: directed self-checking bench for the feedback comb filter
module tb_filter_feedback;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] y;
  int lat;
  int pulses;

  filter_feedback_if #(.GAIN_W(8)) bus();
  filter_feedback #(.DELAY_LEN(1024), .ADDR_W(10), .GAIN_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_clear();
    int cnt = 0;
    logic bad = 0;
    rst_n = 0;
    bus.in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_audio_out", 32'(bus.audio_out), 0);
    rst_n = 1;
    while (!bus.in_ready && cnt < 2000) begin
      if (bus.out_valid || bus.audio_out != 16'h0) bad = 1;
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles", cnt, 1024);
    check("clear_outputs_quiet", 32'(bad), 0);
  endtask

  task automatic send(input logic [15:0] xin, input logic [7:0] gin, output logic [15:0] yout, output int l);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(bus.in_ready), 1);
    bus.audio_in = xin;
    bus.gain = gin;
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    l = 1;
    while (!bus.out_valid && l < 10) begin
      @(negedge clk);
      l++;
    end
    check("out_valid_wait", 32'(bus.out_valid), 1);
    yout = bus.audio_out;
  endtask

  initial begin
    bus.audio_in = 0;
    bus.gain = 0;
    bus.in_valid = 0;
    reset_clear();

    send(16'h1234, 8'd0, y, lat);
    check("g0_value", 32'(y), 32'h1234);
    check("g0_latency", lat, 3);
    @(negedge clk);
    check("g0_ready_back", 32'(bus.in_ready), 1);
    check("g0_single_pulse", 32'(bus.out_valid), 0);

    bus.audio_in = 16'h1111;
    bus.gain = 8'd0;
    bus.in_valid = 1;
    @(negedge clk);
    bus.audio_in = 16'h2222;
    check("read_not_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    bus.in_valid = 0;
    pulses = 0;
    repeat (8) begin
      if (bus.out_valid) begin
        pulses++;
        y = bus.audio_out;
      end
      @(negedge clk);
    end
    check("read_pulse_count", pulses, 1);
    check("read_pulse_value", 32'(y), 32'h1111);

    reset_clear();
    for (int n = 0; n < 2050; n++) begin
      send((n == 0) ? 16'h4000 : 16'h0000, 8'd128, y, lat);
      check($sformatf("impulse_half[%0d]", n), 32'(y),
            (n == 0) ? 32'h4000 : (n == 1024) ? 32'h2000 : (n == 2048) ? 32'h1000 : 32'h0);
    end

    reset_clear();
    for (int n = 0; n < 1030; n++) begin
      send(16'h7000, 8'd255, y, lat);
      check($sformatf("sat_pos[%0d]", n), 32'(y), (n < 1024) ? 32'h7000 : 32'h7FFF);
    end

    reset_clear();
    for (int n = 0; n < 1030; n++) begin
      send(16'h9000, 8'd255, y, lat);
      check($sformatf("sat_neg[%0d]", n), 32'(y), (n < 1024) ? 32'h9000 : 32'h8000);
    end

    reset_clear();
    for (int n = 0; n < 3073; n++) begin
      send((n == 0) ? 16'hFFFF : 16'h0000, 8'd128, y, lat);
      check($sformatf("floor_persist[%0d]", n), 32'(y), (n % 1024 == 0) ? 32'hFFFF : 32'h0);
    end

    reset_clear();
    send(16'h4000, 8'd128, y, lat);
    check("midrst_first", 32'(y), 32'h4000);
    @(negedge clk);
    bus.audio_in = 16'h0100;
    bus.gain = 8'd128;
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    @(negedge clk);
    check("midrst_held_before", 32'(bus.audio_out), 32'h4000);
    rst_n = 0;
    #1;
    check("midrst_audio_out", 32'(bus.audio_out), 0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("midrst_no_write_pulse", 32'(bus.out_valid), 0);
    reset_clear();
    for (int n = 0; n < 1025; n++) begin
      send(16'h0000, 8'd128, y, lat);
      check($sformatf("midrst_cleared[%0d]", n), 32'(y), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
